// File: rtl/hanoi_move_engine.sv
// ---------------------------------------------------------------------------
// hanoi_move_engine
//   Towers-of-Hanoi state engine. Move requests arrive on a valid/ready
//   handshake, are legality-checked, then committed or rejected. The verdict
//   is returned on a second valid/ready handshake. The engine also tracks the
//   legal-move count and whether the puzzle is solved.
//
//   Optional feature: define HANOI_UNDO_EN to add the 'undo' input and an
//   UNDO_DEPTH-deep history of committed moves (oldest dropped when full).
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   move_valid/move_ready    request handshake
//   move_from/move_to        source/destination rod (out-of-range allowed)
//   undo                     (HANOI_UNDO_EN only) reverse the last committed move
//   resp_valid/resp_ready    response handshake
//   resp_ok/resp_err         1 = committed; error code (0 when ok)
//   move_count               committed legal moves (saturating)
//   rod_height               disks per rod, rod i at [i*SZ_W +: SZ_W]
//   solved                   every disk on one rod other than START_ROD
//
// Error codes: 1 bad rod, 2 same rod, 3 empty source, 4 larger on smaller,
//              5 locked (already solved), 6 undo history empty.
// ---------------------------------------------------------------------------
module hanoi_move_engine #(
   parameter int NUM_RODS   = 3,
   parameter int NUM_DISKS  = 4,
   parameter int START_ROD  = 0,
   parameter int CNT_W      = 16,
   parameter int UNDO_DEPTH = 8,
   localparam int ROD_W = $clog2(NUM_RODS) + 1,
   localparam int SZ_W  = $clog2(NUM_DISKS + 1),
   localparam int ERR_W = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      move_valid,
   output logic                      move_ready,
   input  logic [ROD_W-1:0]          move_from,
   input  logic [ROD_W-1:0]          move_to,
`ifdef HANOI_UNDO_EN
   input  logic                      undo,
`endif
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic                      resp_ok,
   output logic [ERR_W-1:0]          resp_err,
   output logic [CNT_W-1:0]          move_count,
   output logic [NUM_RODS*SZ_W-1:0]  rod_height,
   output logic                      solved
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                state_reg, state_next;
   logic [ROD_W-1:0]      from_reg, to_reg;
   logic                  ok_reg;
   logic [ERR_W-1:0]      err_reg, err_next;
   logic [CNT_W-1:0]      count_reg;
   logic                  solved_reg;
   logic                  commit;
   logic                  undo_reg;

   logic [SZ_W-1:0]       height_w [NUM_RODS];
   logic [SZ_W-1:0]       top_w    [NUM_RODS];
   logic [SZ_W-1:0]       h_from, h_to, t_from, t_to;

   // ---------------- per-rod storage ----------------
   for (genvar gi = 0; gi < NUM_RODS; gi++) begin : g_rod
      logic [SZ_W-1:0] height_reg;
      logic [SZ_W-1:0] data_reg [NUM_DISKS];
      logic [SZ_W-1:0] rod_top;
      logic            is_from, is_to;

      assign is_from = (from_reg == ROD_W'(gi));
      assign is_to   = (to_reg   == ROD_W'(gi));

      always_comb begin
         rod_top = '0;
         for (int k = 0; k < NUM_DISKS; k++)
            if (height_reg == SZ_W'(k + 1)) rod_top = data_reg[k];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            height_reg <= (gi == START_ROD) ? SZ_W'(NUM_DISKS) : '0;
            for (int k = 0; k < NUM_DISKS; k++)
               data_reg[k] <= (gi == START_ROD) ? SZ_W'(NUM_DISKS - k) : '0;
         end else if (commit) begin
            // from != to is guaranteed for any committed move
            if (is_from) begin
               height_reg <= height_reg - 1'b1;
               for (int k = 0; k < NUM_DISKS; k++)
                  if (height_reg == SZ_W'(k + 1)) data_reg[k] <= '0;
            end else if (is_to) begin
               height_reg <= height_reg + 1'b1;
               for (int k = 0; k < NUM_DISKS; k++)
                  if (height_reg == SZ_W'(k)) data_reg[k] <= t_from;
            end
         end
      end

      assign height_w[gi] = height_reg;
      assign top_w[gi]    = rod_top;
      assign rod_height[gi*SZ_W +: SZ_W] = height_reg;
   end

`ifdef HANOI_UNDO_EN
   // ---------------- undo history (circular LIFO) ----------------
   localparam int PTR_W  = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
   localparam int LCNT_W = $clog2(UNDO_DEPTH + 1);

   logic [2*ROD_W-1:0] lifo_mem [UNDO_DEPTH];
   logic [PTR_W-1:0]   wp_reg, top_idx;
   logic [LCNT_W-1:0]  lifo_cnt_reg;
   logic [2*ROD_W-1:0] lifo_top;

   assign top_idx  = (wp_reg == '0) ? PTR_W'(UNDO_DEPTH - 1) : wp_reg - 1'b1;
   assign lifo_top = lifo_mem[top_idx];

   always_ff @(posedge clk) begin
      if (commit && !undo_reg) lifo_mem[wp_reg] <= {from_reg, to_reg};
   end

   // When full the write pointer simply overwrites the oldest slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_reg       <= '0;
         lifo_cnt_reg <= '0;
      end else if (commit) begin
         if (undo_reg) begin
            wp_reg       <= top_idx;
            lifo_cnt_reg <= lifo_cnt_reg - 1'b1;
         end else begin
            wp_reg <= (wp_reg == PTR_W'(UNDO_DEPTH - 1)) ? '0 : wp_reg + 1'b1;
            if (lifo_cnt_reg != LCNT_W'(UNDO_DEPTH)) lifo_cnt_reg <= lifo_cnt_reg + 1'b1;
         end
      end
   end
`endif

   // ---------------- legality check ----------------
   always_comb begin
      h_from = '0;
      t_from = '0;
      h_to   = '0;
      t_to   = '0;
      for (int r = 0; r < NUM_RODS; r++) begin
         if (from_reg == ROD_W'(r)) begin
            h_from = height_w[r];
            t_from = top_w[r];
         end
         if (to_reg == ROD_W'(r)) begin
            h_to = height_w[r];
            t_to = top_w[r];
         end
      end

      err_next = '0;
`ifdef HANOI_UNDO_EN
      // An undo replays a move that was legal, reversed, so only emptiness matters.
      if (undo_reg) begin
         if (lifo_cnt_reg == '0) err_next = ERR_W'(6);
      end else
`endif
      if (from_reg >= ROD_W'(NUM_RODS) || to_reg >= ROD_W'(NUM_RODS)) err_next = ERR_W'(1);
      else if (from_reg == to_reg)                                     err_next = ERR_W'(2);
      else if (h_from == '0)                                           err_next = ERR_W'(3);
      else if (h_to != '0 && t_from > t_to)                            err_next = ERR_W'(4);
      else if (solved_reg)                                             err_next = ERR_W'(5);
   end

   assign commit = (state_reg == EXEC) && (err_next == '0);

   // ---------------- FSM ----------------
   always_comb begin
      state_next = state_reg;
      move_ready = 1'b0;
      resp_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            move_ready = 1'b1;
            if (move_valid) state_next = EXEC;
         end
         EXEC: state_next = RESP;
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         from_reg   <= '0;
         to_reg     <= '0;
         undo_reg   <= 1'b0;
         ok_reg     <= 1'b0;
         err_reg    <= '0;
         count_reg  <= '0;
         solved_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && move_valid) begin
`ifdef HANOI_UNDO_EN
            undo_reg <= undo;
            if (undo) begin
               // reversed: destination of the last move becomes the source
               from_reg <= lifo_top[ROD_W-1:0];
               to_reg   <= lifo_top[2*ROD_W-1:ROD_W];
            end else begin
               from_reg <= move_from;
               to_reg   <= move_to;
            end
`else
            undo_reg <= 1'b0;
            from_reg <= move_from;
            to_reg   <= move_to;
`endif
         end
         if (state_reg == EXEC) begin
            ok_reg  <= (err_next == '0);
            err_reg <= err_next;
         end
         if (commit) begin
            if (undo_reg) begin
               if (count_reg != '0) count_reg <= count_reg - 1'b1;
               // the state before any committed move was unsolved
               solved_reg <= 1'b0;
            end else begin
               if (count_reg != {CNT_W{1'b1}}) count_reg <= count_reg + 1'b1;
               // one disk moved: solved iff the destination just became full
               solved_reg <= (to_reg != ROD_W'(START_ROD)) && (h_to == SZ_W'(NUM_DISKS - 1));
            end
         end
      end
   end

   assign resp_ok    = ok_reg;
   assign resp_err   = err_reg;
   assign move_count = count_reg;
   assign solved     = solved_reg;

endmodule

// File: tb/tb_hanoi_move_engine.sv
module tb_hanoi_move_engine;
   localparam int NR = 3;
   localparam int ND = 3;
   localparam int SR = 0;
   localparam int CW = 16;
   localparam int RW = $clog2(NR) + 1;
   localparam int SW = $clog2(ND + 1);

   logic clk = 1'b0;
   logic rst;
   logic move_valid, move_ready;
   logic [RW-1:0] move_from, move_to;
   logic resp_valid, resp_ready, resp_ok;
   logic [2:0] resp_err;
   logic [CW-1:0] move_count;
   logic [NR*SW-1:0] rod_height;
   logic solved;
`ifdef HANOI_UNDO_EN
   logic undo;
`endif

   hanoi_move_engine #(.NUM_RODS(NR), .NUM_DISKS(ND), .START_ROD(SR), .CNT_W(CW), .UNDO_DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .move_valid(move_valid), .move_ready(move_ready),
      .move_from(move_from), .move_to(move_to),
`ifdef HANOI_UNDO_EN
      .undo(undo),
`endif
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_ok(resp_ok), .resp_err(resp_err),
      .move_count(move_count), .rod_height(rod_height), .solved(solved)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic longint flat(input int h0, input int h1, input int h2);
      return longint'(h0) | (longint'(h1) << SW) | (longint'(h2) << (2 * SW));
   endfunction

   // ---------------- reference model: rods as stacks of disk sizes ----------------
   int mdata[NR][ND];
   int mh[NR];
   int mcount;

   function automatic void m_reset();
      for (int r = 0; r < NR; r++) mh[r] = 0;
      for (int k = 0; k < ND; k++) mdata[SR][k] = ND - k;
      mh[SR] = ND;
      mcount = 0;
   endfunction

   function automatic int m_solved();
      for (int r = 0; r < NR; r++)
         if (r != SR && mh[r] == ND) return 1;
      return 0;
   endfunction

   function automatic longint m_flat();
      longint v = 0;
      for (int r = 0; r < NR; r++) v |= longint'(mh[r]) << (r * SW);
      return v;
   endfunction

   function automatic void m_move(input int f, input int t, output int ok, output int err);
      err = 0;
      if (f >= NR || t >= NR)                              err = 1;
      else if (f == t)                                     err = 2;
      else if (mh[f] == 0)                                 err = 3;
      else if (mh[t] != 0 && mdata[f][mh[f]-1] > mdata[t][mh[t]-1]) err = 4;
      else if (m_solved() != 0)                            err = 5;
      if (err == 0) begin
         mdata[t][mh[t]] = mdata[f][mh[f]-1];
         mh[t]++;
         mh[f]--;
         if (mcount < (1 << CW) - 1) mcount++;
      end
      ok = (err == 0) ? 1 : 0;
   endfunction

   // ---------------- drivers (called at a negedge, return at a negedge) ----------------
   task automatic do_reset();
      rst = 1'b1;
      move_valid = 1'b0;
      resp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   // f < 0 requests an undo (only meaningful when the undo feature is built)
   task automatic send(input int f, input int t, output logic ok, output logic [2:0] err);
      int n = 0;
      while (!move_ready && n < 50) begin @(negedge clk); n++; end
      if (!move_ready) begin
         n_total++;
         $display("FAIL ready_timeout: got move_ready 0 expected 1");
      end
      move_valid = 1'b1;
      move_from  = f[RW-1:0];
      move_to    = t[RW-1:0];
`ifdef HANOI_UNDO_EN
      undo = (f < 0);
`endif
      @(negedge clk);
      move_valid = 1'b0;
`ifdef HANOI_UNDO_EN
      undo = 1'b0;
`endif
      n = 0;
      while (!resp_valid && n < 20) begin @(negedge clk); n++; end
      if (!resp_valid) begin
         n_total++;
         $display("FAIL resp_timeout: got resp_valid 0 expected 1");
      end
      ok  = resp_ok;
      err = resp_err;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   typedef struct {
      int rst_first; int f; int t;
      int ok; int err; int cnt; int h0; int h1; int h2; int slv;
   } vec_t;
   localparam int NV = 16;
   vec_t vecs[NV];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic gok;
      logic [2:0] gerr;

      // rst_first, from, to, ok, err, count, h0, h1, h2, solved
      vecs[0]  = '{1, 0, 3, 0, 1, 0, 3, 0, 0, 0};
      vecs[1]  = '{0, 7, 7, 0, 1, 0, 3, 0, 0, 0};
      vecs[2]  = '{0, 1, 1, 0, 2, 0, 3, 0, 0, 0};
      vecs[3]  = '{0, 1, 2, 0, 3, 0, 3, 0, 0, 0};
      vecs[4]  = '{0, 0, 1, 1, 0, 1, 2, 1, 0, 0};
      vecs[5]  = '{0, 0, 1, 0, 4, 1, 2, 1, 0, 0};
      vecs[6]  = '{1, 0, 2, 1, 0, 1, 2, 0, 1, 0};
      vecs[7]  = '{0, 0, 1, 1, 0, 2, 1, 1, 1, 0};
      vecs[8]  = '{0, 2, 1, 1, 0, 3, 1, 2, 0, 0};
      vecs[9]  = '{0, 0, 2, 1, 0, 4, 0, 2, 1, 0};
      vecs[10] = '{0, 1, 0, 1, 0, 5, 1, 1, 1, 0};
      vecs[11] = '{0, 1, 2, 1, 0, 6, 1, 0, 2, 0};
      vecs[12] = '{0, 0, 2, 1, 0, 7, 0, 0, 3, 1};
      vecs[13] = '{0, 2, 1, 0, 5, 7, 0, 0, 3, 1};
      vecs[14] = '{0, 5, 1, 0, 1, 7, 0, 0, 3, 1};
      vecs[15] = '{0, 2, 2, 0, 2, 7, 0, 0, 3, 1};

      rst = 1'b1; move_valid = 1'b0; resp_ready = 1'b0;
      move_from = '0; move_to = '0;
`ifdef HANOI_UNDO_EN
      undo = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_reset();

      // reset state
      chk("rst_move_ready", move_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_ok", resp_ok, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_move_count", move_count, 0);
      chk("rst_heights", rod_height, flat(3, 0, 0));
      chk("rst_solved", solved, 0);

      // illegal moves then optimal solve and lock
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].rst_first != 0) do_reset();
         send(vecs[i].f, vecs[i].t, gok, gerr);
         chk($sformatf("vec%0d_ok", i), gok, vecs[i].ok);
         chk($sformatf("vec%0d_err", i), gerr, vecs[i].err);
         chk($sformatf("vec%0d_count", i), move_count, vecs[i].cnt);
         chk($sformatf("vec%0d_heights", i), rod_height, flat(vecs[i].h0, vecs[i].h1, vecs[i].h2));
         chk($sformatf("vec%0d_solved", i), solved, vecs[i].slv);
      end

      // held response with a second request waiting
      do_reset();
      move_valid = 1'b1; move_from = 3'd0; move_to = 3'd2;
      @(negedge clk);
      move_from = 3'd0; move_to = 3'd1;
      chk("hold_exec_ready", move_ready, 0);
      chk("hold_exec_resp_valid", resp_valid, 0);
      @(negedge clk);
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_resp_ok", resp_ok, 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("hold%0d_resp_valid", c), resp_valid, 1);
         chk($sformatf("hold%0d_resp_ok", c), resp_ok, 1);
         chk($sformatf("hold%0d_resp_err", c), resp_err, 0);
         chk($sformatf("hold%0d_move_ready", c), move_ready, 0);
         chk($sformatf("hold%0d_count", c), move_count, 1);
         chk($sformatf("hold%0d_heights", c), rod_height, flat(2, 0, 1));
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("hold_idle_ready", move_ready, 1);
      @(negedge clk);
      move_valid = 1'b0;
      chk("hold_second_exec_count", move_count, 1);
      @(negedge clk);
      chk("hold_second_resp_valid", resp_valid, 1);
      chk("hold_second_ok", resp_ok, 1);
      chk("hold_second_count", move_count, 2);
      chk("hold_second_heights", rod_height, flat(1, 1, 1));
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;

      // reset during EXEC
      do_reset();
      move_valid = 1'b1; move_from = 3'd0; move_to = 3'd2;
      @(negedge clk);
      move_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rexec_resp_valid", resp_valid, 0);
      chk("rexec_move_ready", move_ready, 1);
      chk("rexec_count", move_count, 0);
      chk("rexec_heights", rod_height, flat(3, 0, 0));
      @(negedge clk);
      chk("rexec_resp_valid_later", resp_valid, 0);

      // reset during RESP
      move_valid = 1'b1; move_from = 3'd0; move_to = 3'd2;
      @(negedge clk);
      move_valid = 1'b0;
      @(negedge clk);
      chk("rresp_resp_valid_before", resp_valid, 1);
      chk("rresp_count_before", move_count, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rresp_resp_valid", resp_valid, 0);
      chk("rresp_resp_ok", resp_ok, 0);
      chk("rresp_count", move_count, 0);
      chk("rresp_heights", rod_height, flat(3, 0, 0));
      chk("rresp_solved", solved, 0);

`ifdef HANOI_UNDO_EN
      do_reset();
      send(0, 2, gok, gerr); chk("undo_mv1_ok", gok, 1);
      send(0, 1, gok, gerr); chk("undo_mv2_ok", gok, 1);
      send(-1, 0, gok, gerr); chk("undo1_ok", gok, 1);
      send(-1, 0, gok, gerr); chk("undo2_ok", gok, 1);
      chk("undo_count", move_count, 0);
      chk("undo_heights", rod_height, flat(3, 0, 0));
      send(-1, 0, gok, gerr);
      chk("undo_empty_ok", gok, 0);
      chk("undo_empty_err", gerr, 6);
      send(0, 2, gok, gerr); chk("undo_order_ok", gok, 1);
      send(0, 2, gok, gerr); chk("undo_order_err", gerr, 4);
`endif

      // randomized moves against the model
      do_reset();
      for (int i = 0; i < 300; i++) begin
         int f, t, eok, eerr;
         f = $urandom_range(0, NR);
         t = $urandom_range(0, NR);
         m_move(f, t, eok, eerr);
         send(f, t, gok, gerr);
         chk($sformatf("rnd%0d_ok", i), gok, eok);
         chk($sformatf("rnd%0d_err", i), gerr, eerr);
         chk($sformatf("rnd%0d_count", i), move_count, mcount);
         chk($sformatf("rnd%0d_heights", i), rod_height, m_flat());
         chk($sformatf("rnd%0d_solved", i), solved, m_solved());
         if (m_solved() != 0 && $urandom_range(0, 3) == 0) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
